ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-client arbiter that sits directly upstream of one altsyncram port in SINGLE_PORT mode and drives its address, data, wren and rden inputs.
- Grants one of two request/grant clients per cycle, using round-robin with a bounded burst hold.
- Tracks the RAM read latency so each read result comes back to the client that issued it, with a valid strobe.
- Typical use: sharing one block RAM between the CPU-side and PPU-side fetch engines.

Parameters:
- DATA_W, 8, data width; equals RAM width_a.
- ADDR_W, 11, address width; equals RAM widthad_a.
- RD_LATENCY, 1, cycles from an accepted read to valid ram_q. Legal values: 1 (outdata UNREGISTERED) or 2 (outdata registered on clock0).
- MAX_BURST, 4, maximum consecutive grants to one client while the other client is requesting. Range 1..15.

Ports:
- clock0  in  1  sole clock; all state updates on the rising edge.
- aclr0  in  1  asynchronous reset, active-high.
- a_req  in  1  client A requests an access this cycle.
- a_we  in  1  client A access is a write (1) or a read (0).
- a_addr  in  ADDR_W  client A address.
- a_wdata  in  DATA_W  client A write data.
- a_gnt  out  1  client A request accepted this cycle (combinational).
- a_rvalid  out  1  a_rdata holds the result of a client A read.
- a_rdata  out  DATA_W  client A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as client A, for client B.
- ram_address  out  ADDR_W  to RAM address_a.
- ram_data  out  DATA_W  to RAM data_a.
- ram_wren  out  1  to RAM wren_a.
- ram_rden  out  1  to RAM rden_a.
- ram_q  in  DATA_W  from RAM q_a.

Behaviour:
- Reset (aclr0=1, asynchronous):
  - owner=none, last_served=B, burst_cnt=0, return pipeline cleared.
  - a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - ram_wren=ram_rden=0, ram_address=0, ram_data=0.
  - A request that was in flight when reset asserts is dropped; no rvalid for it after reset releases.
- Handshake: an access is accepted in the cycle where req=1 and gnt=1. The client holds req, we, addr and wdata stable until accepted. Grant is combinational from req and registered state; at most one gnt per cycle.
- Arbitration, evaluated each cycle:
  - Neither request: no grant.
  - One request: grant that client.
  - Both request and owner=X and burst_cnt<MAX_BURST: grant X.
  - Both request otherwise (no owner, or burst limit reached): grant the client that is not last_served.
- State update at the clock edge:
  - Grant to client X: if owner==X, burst_cnt+1 (saturating at 15); else burst_cnt=1. Then owner=X, last_served=X.
  - No grant: owner=none, burst_cnt=0. last_served is held.
- RAM drive, combinational from the granted client:
  - ram_address=addr, ram_data=wdata, ram_wren=gnt&we, ram_rden=gnt&~we.
  - With no grant: ram_wren=ram_rden=0; address and data hold their last driven values.
- Read return:
  - A shift pipeline of depth RD_LATENCY carries {valid, client_id} for each accepted read.
  - At the pipeline tail, the matching rvalid pulses for one cycle.
  - rdata is the registered capture of ram_q taken in that cycle, so rvalid and rdata appear RD_LATENCY+1 cycles after acceptance.
  - rdata holds its value until the next rvalid for the same client.
  - Reads can be accepted back-to-back, one per cycle; the pipeline never stalls.
- Writes: no rvalid. A write followed by a read to the same address on the next accepted cycle returns the new data, because RAM writes complete in the acceptance cycle.
- Parameter legality: RD_LATENCY outside {1,2} or MAX_BURST outside 1..15 is rejected at elaboration by a generate-time check.

Test Plan:
- Reset, then a_req=1, a_we=0, a_addr=0x010 with RAM preloaded 0x5A there (RD_LATENCY=1) -> a_gnt=1 in cycle 0; a_rvalid=1 with a_rdata=0x5A in cycle 2; b_rvalid stays 0.
- First cycle after reset with a_req=b_req=1 -> A granted first (last_served=B). With both held and MAX_BURST=4: grants are A,A,A,A,B,B,B,B,A…
- b_req held, a_req pulsed on alternate cycles -> B granted whenever A is idle; no cycle has both grants; ram_wren/ram_rden follow the granted client.
- A writes 0xC3 to 0x7FF, then B reads 0x7FF on the next cycle -> b_rdata=0xC3 with b_rvalid after RD_LATENCY+1 cycles. Repeat with RD_LATENCY=2 -> 3-cycle return.
- aclr0 pulsed one cycle after an A read is accepted -> no a_rvalid afterwards; a_gnt=b_gnt=0 while aclr0=1; arbitration restarts with A priority.
- Alternating A and B reads every cycle to addresses 0x001..0x008 -> each rvalid reaches the issuing client in issue order with the correct data.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-client round-robin arbiter with burst hold in front of a single-port altsyncram,
// routing each read result back to the client that issued it.
module ram_port_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 11,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic              clock0,
  input  logic              aclr0,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);
  if (RD_LATENCY < 1 || RD_LATENCY > 2 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_params
    $error("ram_port_arbiter: RD_LATENCY must be 1..2 and MAX_BURST 1..15");
  end
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  owner_t owner, owner_nxt;
  logic last_b, last_b_nxt, hold, pick_a, tail_v, tail_b;
  logic [3:0] burst_cnt, burst_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [RD_LATENCY-1:0] pv, pid;
  assign tail_v = pv[RD_LATENCY-1];
  assign tail_b = pid[RD_LATENCY-1];
  always_comb begin
    hold        = owner != OWN_NONE && burst_cnt < MAXB;
    pick_a      = hold ? owner == OWN_A : last_b;
    a_gnt       = ~aclr0 & a_req & (~b_req | pick_a);
    b_gnt       = ~aclr0 & b_req & (~a_req | ~pick_a);
    owner_nxt   = a_gnt ? OWN_A : b_gnt ? OWN_B : OWN_NONE;
    burst_nxt   = owner_nxt == OWN_NONE ? 4'd0 :
                  owner_nxt != owner ? 4'd1 :
                  burst_cnt == 4'hf ? burst_cnt : burst_cnt + 4'd1;
    last_b_nxt  = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b;
    ram_address = a_gnt ? a_addr : b_gnt ? b_addr : addr_q;
    ram_data    = a_gnt ? a_wdata : b_gnt ? b_wdata : data_q;
    ram_wren    = (a_gnt & a_we) | (b_gnt & b_we);
    ram_rden    = (a_gnt & ~a_we) | (b_gnt & ~b_we);
  end
  // pv/pid track each accepted read until its data is on ram_q
  always_ff @(posedge clock0 or posedge aclr0)
    if (aclr0) begin
      owner     <= OWN_NONE;
      last_b    <= 1'b1;
      burst_cnt <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      pv        <= '0;
      pid       <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      owner     <= owner_nxt;
      last_b    <= last_b_nxt;
      burst_cnt <= burst_nxt;
      addr_q    <= ram_address;
      data_q    <= ram_data;
      pv[0]     <= ram_rden;
      pid[0]    <= b_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      a_rvalid <= tail_v & ~tail_b;
      b_rvalid <= tail_v & tail_b;
      if (tail_v & ~tail_b) a_rdata <= ram_q;
      if (tail_v & tail_b) b_rdata <= ram_q;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven grant checks plus a read-return scoreboard for RD_LATENCY 1 and 2.
module tb_ram_port_arbiter;
  logic clk = 1'b0, aclr0 = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [10:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wren, ram_rden;
  logic [7:0] a_rdata, b_rdata, ram_data, ram_q;
  logic [10:0] ram_address;
  logic a_gnt2, a_rvalid2, b_gnt2, b_rvalid2, ram_wren2, ram_rden2;
  logic [7:0] a_rdata2, b_rdata2, ram_data2, ram_q2, ram_q2a;
  logic [10:0] ram_address2;
  logic [7:0] m1 [2048], m2 [2048], ref_mem [2048];
  bit w1 [2048], w2 [2048];
  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic rst, ar, aw;
    logic [10:0] aa;
    logic [7:0] ad;
    logic br, bw;
    logic [10:0] ba;
    logic [7:0] bd;
    logic ga, gb;
  } vec_t;
  typedef struct {
    logic id;
    logic [7:0] d;
    int due;
  } exp_t;
  vec_t vq[$];
  exp_t q1[$], q2[$];

  ram_port_arbiter #(.DATA_W(8), .ADDR_W(11), .RD_LATENCY(1), .MAX_BURST(4)) dut (
    .clock0(clk), .aclr0(aclr0),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_q(ram_q));

  ram_port_arbiter #(.DATA_W(8), .ADDR_W(11), .RD_LATENCY(2), .MAX_BURST(4)) dut2 (
    .clock0(clk), .aclr0(aclr0),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
    .ram_address(ram_address2), .ram_data(ram_data2), .ram_wren(ram_wren2),
    .ram_rden(ram_rden2), .ram_q(ram_q2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [10:0] a);
    return a == 11'h010 ? 8'h5A : 8'(a) * 8'd13 + 8'd7;
  endfunction

  // RAM models: unregistered q for dut, extra output register for dut2
  always @(posedge clk) begin
    if (ram_wren) begin m1[ram_address] <= ram_data; w1[ram_address] <= 1'b1; end
    if (ram_rden) ram_q <= w1[ram_address] ? m1[ram_address] : init_val(ram_address);
    if (ram_wren2) begin m2[ram_address2] <= ram_data2; w2[ram_address2] <= 1'b1; end
    if (ram_rden2) ram_q2a <= w2[ram_address2] ? m2[ram_address2] : init_val(ram_address2);
    ram_q2 <= ram_q2a;
  end

  function automatic vec_t mk(input logic rst, ar, aw, input logic [10:0] aa, input logic [7:0] ad,
                              input logic br, bw, input logic [10:0] ba, input logic [7:0] bd,
                              input logic ga, gb);
    vec_t v;
    v.rst = rst; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd; v.ga = ga; v.gb = gb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic ret(input int k, input logic rv, input logic id, input logic [7:0] d);
    exp_t e;
    if (!rv) return;
    if ((k == 0 && q1.size() == 0) || (k == 1 && q2.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL ret_unexpected dut=%0d cyc=%0d client=%0d data=%h", k, cyc, id, d);
    end else begin
      if (k == 0) e = q1.pop_front();
      else e = q2.pop_front();
      chk($sformatf("ret_dut%0d {client,data,cycle}", k), {23'd0, id, d, 32'(cyc)}, {23'd0, e.id, e.d, 32'(e.due)});
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic ewe, ere;
    logic [10:0] eaddr;
    logic [7:0] edata;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(11'(i));
    vq.push_back(mk(1, 1, 0, 11'h010, 0, 1, 0, 11'h020, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 11'h010, 0, 0, 0, 0, 0, 1, 0));
    repeat (3) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 11'h001, 0, 1, 0, 11'h002, 0, 0, 0));
    for (int k = 0; k < 9; k++)
      vq.push_back(mk(0, 1, 0, 11'h001, 0, 1, 0, 11'h002, 0, k < 4 || k == 8, k >= 4 && k < 8));
    repeat (2) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(0, k[0], 1, 11'h100, 8'hA0 + 8'(k), 1, 0, 11'h100, 0, k == 5, k != 5));
    repeat (2) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 11'h7FF, 8'hC3, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 11'h7FF, 0, 0, 1));
    repeat (3) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 11'h010, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 0, 11'h010, 0, 1, 0, 11'h020, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 11'h003, 0, 1, 0, 11'h004, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 11'h004, 0, 0, 1));
    repeat (2) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(0, !k[0], 0, 11'(k + 1), 0, k[0], 0, 11'(k + 1), 0, !k[0], k[0]));
    repeat (3) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk);
      #1;
      aclr0 = v.rst; a_req = v.ar; a_we = v.aw; a_addr = v.aa; a_wdata = v.ad;
      b_req = v.br; b_we = v.bw; b_addr = v.ba; b_wdata = v.bd;
      @(negedge clk);
      chk($sformatf("grants row%0d", i), {60'd0, a_gnt, b_gnt, a_gnt2, b_gnt2}, {60'd0, v.ga, v.gb, v.ga, v.gb});
      ewe = v.ga ? v.aw : v.gb ? v.bw : 1'b0;
      ere = (v.ga | v.gb) & ~ewe;
      chk($sformatf("wren_rden row%0d", i), {60'd0, ram_wren, ram_rden, ram_wren2, ram_rden2}, {60'd0, ewe, ere, ewe, ere});
      if (v.ga | v.gb) begin
        eaddr = v.ga ? v.aa : v.ba;
        edata = v.ga ? v.ad : v.bd;
        chk($sformatf("ram_addr_data row%0d", i), {26'd0, ram_address, ram_data, ram_address2, ram_data2},
            {26'd0, eaddr, edata, eaddr, edata});
      end
      if (v.rst) begin
        q1.delete();
        q2.delete();
        chk($sformatf("reset_outputs row%0d", i),
            {a_rvalid, b_rvalid, a_rdata, b_rdata, ram_address, ram_data, a_rvalid2, b_rvalid2, a_rdata2, b_rdata2},
            64'd0);
        chk($sformatf("reset_ram_drive2 row%0d", i), {33'd0, ram_address2, ram_data2, ram_wren, ram_rden, ram_wren2, ram_rden2}, 64'd0);
      end else begin
        ret(0, a_rvalid, 1'b0, a_rdata);
        ret(0, b_rvalid, 1'b1, b_rdata);
        ret(1, a_rvalid2, 1'b0, a_rdata2);
        ret(1, b_rvalid2, 1'b1, b_rdata2);
        if (ewe) ref_mem[v.ga ? v.aa : v.ba] = v.ga ? v.ad : v.bd;
        if (ere) begin
          e.id = v.gb;
          e.d = ref_mem[v.ga ? v.aa : v.ba];
          e.due = cyc + 2;
          q1.push_back(e);
          e.due = cyc + 3;
          q2.push_back(e);
        end
      end
    end
    chk("pending_returns", {32'(q1.size()), 32'(q2.size())}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
